// File: rtl/lfsr_sched_pkg.sv
// lfsr_sched_pkg: shared types for the LFSR job scheduler.
// Contents: FSM state enum, skip-counter width helper.
package lfsr_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HOLD,
    S_FLUSH
  } state_e;

  function automatic int SKIP_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lfsr_sched_if.sv
// lfsr_sched_if: output word stream (valid/ready).
// Signals: out_data, out_id, out_last, out_valid, out_ready.
interface lfsr_sched_if
  import lfsr_sched_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = 2
);
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_id;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data, out_id, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_id, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/lfsr_sched_rr_arbiter.sv
// rr_arbiter: one-hot grant to first request at/after pointer.
// Ports: clk_i, reset_ni, req_i, en_i, gnt_o, gnt_id_o.
module rr_arbiter
  import lfsr_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_id_o
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_k;
  logic          w_any;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    w_any    = 1'b0;
    w_k      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = IW'((int'(r_ptr) + i) % NUM_REQ);
      if (en_i && !w_any && req_i[w_k]) begin
        w_any      = 1'b1;
        gnt_o[w_k] = 1'b1;
        gnt_id_o   = w_k;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (gnt_id_o == IW'(NUM_REQ - 1)) ?
               '0 : gnt_id_o + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin job scheduler sharing one LFSR.
// Ports: req_* jobs in, out_if word stream, lfsr_* LFSR ctrl.
module lfsr_sched
  import lfsr_sched_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int W       = 8,
  parameter  int NUM_REQ = 4,
  parameter  int LEN_W   = 16,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int XW = (W > 1) ? $clog2(W) : 1,
  localparam int SW = SKIP_W(N)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*N-1:0]     req_taps_i,
  input  logic [NUM_REQ*N-1:0]     req_seed_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_nbits_i,
  lfsr_sched_if.master             out_if,
  output logic                     lfsr_load_o,
  output logic [N-1:0]             lfsr_taps_o,
  output logic [N-1:0]             lfsr_start_o,
  input  logic                     lfsr_data_i,
  input  logic                     lfsr_valid_i,
  output logic                     busy_o
);

  state_e           r_state, w_next;
  logic [N-1:0]     r_taps, r_seed, r_hist;
  logic [LEN_W-1:0] r_rem;
  logic [IW-1:0]    r_id;
  logic [XW-1:0]    r_idx;
  logic [W-1:0]     r_acc;
  logic [SW-1:0]    r_skip;
  logic [W-1:0]     r_out_data;
  logic [IW-1:0]    r_out_id;
  logic             r_out_last;
  logic             r_out_valid;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gid;
  logic               w_arb_en, w_hs;
  logic               w_can_out, w_take;
  logic               w_lastbit, w_done;
  logic [LEN_W-1:0]   w_nbits;
  logic [W-1:0]       w_word;

  // Gating with reset keeps ready low while reset is held.
  assign w_arb_en = (r_state == S_IDLE) && reset_ni;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .req_i    (req_valid_i),
    .en_i     (w_arb_en),
    .gnt_o    (w_gnt),
    .gnt_id_o (w_gid)
  );

  assign req_ready_o = w_gnt;
  assign w_hs        = |(req_valid_i & w_gnt);
  assign w_nbits     = req_nbits_i[int'(w_gid)*LEN_W +: LEN_W];

  assign w_can_out = !r_out_valid || out_if.out_ready;
  assign w_take    = (r_state == S_RUN) && lfsr_valid_i &&
                     (r_skip == '0);
  assign w_lastbit = (r_rem == LEN_W'(1));
  assign w_done    = w_take &&
                     ((r_idx == XW'(W - 1)) || w_lastbit);
  // Accumulator starts at zero, so partial words pad to zero.
  assign w_word    = r_acc | (W'(lfsr_data_i) << r_idx);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_hs && (w_nbits != '0)) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN: begin
        if (w_done) begin
          if (w_can_out) w_next = w_lastbit ? S_IDLE : S_RUN;
          else           w_next = w_lastbit ? S_FLUSH : S_HOLD;
        end
      end
      S_HOLD:  if (w_can_out) w_next = S_RUN;
      S_FLUSH: if (w_can_out) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // HOLD reloads the last N bits, pinning the sequence.
  always_comb begin
    lfsr_load_o  = 1'b0;
    lfsr_start_o = '0;
    unique case (r_state)
      S_LOAD: begin
        lfsr_load_o  = 1'b1;
        lfsr_start_o = r_seed;
      end
      S_HOLD: begin
        lfsr_load_o  = 1'b1;
        lfsr_start_o = r_hist;
      end
      default: ;
    endcase
  end

  assign busy_o      = (r_state != S_IDLE);
  assign lfsr_taps_o = r_taps;

  assign out_if.out_data  = r_out_data;
  assign out_if.out_id    = r_out_id;
  assign out_if.out_last  = r_out_last;
  assign out_if.out_valid = r_out_valid;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_taps      <= '0;
      r_seed      <= '0;
      r_hist      <= '0;
      r_rem       <= '0;
      r_id        <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_skip      <= '0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (out_if.out_ready) r_out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_taps <= req_taps_i[int'(w_gid)*N +: N];
            r_seed <= req_seed_i[int'(w_gid)*N +: N];
            r_rem  <= w_nbits;
            r_id   <= w_gid;
            r_idx  <= '0;
            r_acc  <= '0;
            r_skip <= '0;
          end
        end
        S_RUN: begin
          if (lfsr_valid_i) begin
            r_hist <= {lfsr_data_i, r_hist[N-1:1]};
            if (r_skip != '0) begin
              r_skip <= r_skip - 1'b1;
            end else begin
              r_rem <= r_rem - 1'b1;
              if (w_done) begin
                r_idx <= '0;
                if (w_can_out) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_word;
                  r_out_id    <= r_id;
                  r_out_last  <= w_lastbit;
                  r_acc       <= '0;
                end else begin
                  r_acc <= w_word;
                end
              end else begin
                r_acc <= w_word;
                r_idx <= r_idx + 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (w_can_out) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
            r_out_id    <= r_id;
            r_out_last  <= 1'b0;
            r_acc       <= '0;
            r_skip      <= SW'(N);
          end
        end
        S_FLUSH: begin
          if (w_can_out) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
            r_out_id    <= r_id;
            r_out_last  <= 1'b1;
            r_acc       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: scoreboard bench for lfsr_sched.
// Includes a runtime-configurable Fibonacci LFSR peer.
module tb_lfsr_sched;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int NR = 4;
  localparam int LW = 16;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*N-1:0]  req_taps, req_seed;
  logic [NR*LW-1:0] req_nbits;
  logic             lfsr_load;
  logic [N-1:0]     lfsr_taps, lfsr_start;
  logic             lfsr_data, lfsr_valid;
  logic             busy;

  lfsr_sched_if #(.W(W), .IW(IW)) oif ();

  lfsr_sched #(
    .N(N), .W(W), .NUM_REQ(NR), .LEN_W(LW)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_taps_i   (req_taps),
    .req_seed_i   (req_seed),
    .req_nbits_i  (req_nbits),
    .out_if       (oif),
    .lfsr_load_o  (lfsr_load),
    .lfsr_taps_o  (lfsr_taps),
    .lfsr_start_o (lfsr_start),
    .lfsr_data_i  (lfsr_data),
    .lfsr_valid_i (lfsr_valid),
    .busy_o       (busy)
  );

  // LFSR peer: output state[0], feedback ^(state&taps) into MSB.
  logic [N-1:0] m_state;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state    <= '0;
      lfsr_data  <= 1'b0;
      lfsr_valid <= 1'b0;
    end else if (lfsr_load) begin
      m_state    <= lfsr_start;
      lfsr_valid <= 1'b0;
    end else begin
      lfsr_data  <= m_state[0];
      lfsr_valid <= 1'b1;
      m_state    <= {^(m_state & lfsr_taps), m_state[N-1:1]};
    end
  end

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] id;
    logic          last;
  } exp_t;

  exp_t        q[$];
  logic [NR-1:0] glog[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int hs_cnt = 0;
  int first_v = -1;
  int load_cnt = 0;
  bit stalled = 1'b0;
  exp_t held, got, e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_valid & req_ready)) begin
        hs_cyc = cyc;
        hs_cnt++;
        glog.push_back(req_ready);
      end
      if (lfsr_load) load_cnt++;
      if (oif.out_valid && first_v < 0) first_v = cyc;
      got = {oif.out_data, oif.out_id, oif.out_last};
      if (oif.out_valid && !oif.out_ready) begin
        if (stalled) begin
          tests++;
          if (got !== held) begin
            fails++;
            $display("FAIL stall_stable got %h want %h",
                     got, held);
          end
        end
        stalled = 1'b1;
        held = got;
      end else begin
        stalled = 1'b0;
      end
      if (oif.out_valid && oif.out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_word got %h want none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL word got d=%h id=%0d last=%b want d=%h id=%0d last=%b",
                     got.d, got.id, got.last, e.d, e.id, e.last);
          end
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic expw(input logic [W-1:0] d,
                      input logic [IW-1:0] id,
                      input logic last);
    q.push_back({d, id, last});
  endtask

  task automatic set_fields(input int r,
                            input logic [N-1:0] taps,
                            input logic [N-1:0] seed,
                            input logic [LW-1:0] nb);
    req_taps[r*N +: N]    = taps;
    req_seed[r*N +: N]    = seed;
    req_nbits[r*LW +: LW] = nb;
  endtask

  task automatic do_req(input int r,
                        input logic [N-1:0] taps,
                        input logic [N-1:0] seed,
                        input logic [LW-1:0] nb);
    int n;
    n = 0;
    @(posedge clk); #1;
    set_fields(r, taps, seed, nb);
    req_valid[r] = 1'b1;
    @(negedge clk);
    while (!req_ready[r] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL req_timeout got none want grant %0d", r);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while ((busy || oif.out_valid || q.size() != 0) &&
           n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, (n >= maxc) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] g;
    int base;
    int n;
    req_valid = '0;
    req_taps  = '0;
    req_seed  = '0;
    req_nbits = '0;
    oif.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {busy, lfsr_load, oif.out_valid,
                      oif.out_last, req_ready}, 0);
    check("rst_lfsr", {lfsr_taps, lfsr_start}, 0);
    rst_n = 1'b1;

    // Basic 16-bit job
    expw(8'h01, 2'd0, 1'b0);
    expw(8'h81, 2'd0, 1'b1);
    first_v = -1;
    do_req(0, 8'h03, 8'h01, 16'd16);
    wait_idle("t1_idle", 200);
    check("t1_latency", first_v - hs_cyc, 11);

    // Partial final word
    expw(8'h01, 2'd0, 1'b0);
    expw(8'h01, 2'd0, 1'b1);
    do_req(0, 8'h03, 8'h01, 16'd12);
    wait_idle("t2_idle", 200);

    // Backpressure stall: HOLD from cycle 19 to 41
    expw(8'h01, 2'd0, 1'b0);
    expw(8'h81, 2'd0, 1'b0);
    expw(8'h41, 2'd0, 1'b1);
    load_cnt = 0;
    do_req(0, 8'h03, 8'h01, 16'd24);
    while (cyc < hs_cyc + 10) begin
      @(posedge clk); #1;
    end
    oif.out_ready = 1'b0;
    while (cyc < hs_cyc + 41) begin
      @(posedge clk); #1;
    end
    oif.out_ready = 1'b1;
    wait_idle("t3_idle", 200);
    check("t3_load_cycles", load_cnt, 24);

    // Zero-length job on req1
    base = hs_cnt;
    glog.delete();
    do_req(1, 8'h03, 8'h01, 16'd0);
    check("t5_hs_count", hs_cnt - base, 1);
    g = (glog.size() > 0) ? glog[0] : '0;
    check("t5_grant", g, 4'b0010);
    repeat (3) begin
      @(negedge clk);
      check("t5_idle", {busy, oif.out_valid}, 0);
    end

    // Reset mid-RUN
    do_req(0, 8'h03, 8'h01, 16'd16);
    while (cyc < hs_cyc + 6) begin
      @(posedge clk); #1;
    end
    check("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", {busy, lfsr_load, oif.out_valid,
                         oif.out_last, req_ready}, 0);
    check("t6_rst_lfsr", {lfsr_taps, lfsr_start}, 0);
    check("t6_rst_data", {oif.out_data, oif.out_id}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expw(8'h01, 2'd3, 1'b0);
    expw(8'h81, 2'd3, 1'b1);
    first_v = -1;
    do_req(3, 8'h03, 8'h01, 16'd16);
    wait_idle("t6_idle", 200);
    check("t6_latency", first_v - hs_cyc, 11);

    // Round robin between req0 and req2
    glog.delete();
    base = hs_cnt;
    expw(8'h01, 2'd0, 1'b1);
    expw(8'h01, 2'd2, 1'b1);
    expw(8'h01, 2'd0, 1'b1);
    expw(8'h01, 2'd2, 1'b1);
    @(posedge clk); #1;
    set_fields(0, 8'h03, 8'h01, 16'd8);
    set_fields(2, 8'h03, 8'h01, 16'd8);
    req_valid = 4'b0101;
    n = 0;
    while (hs_cnt < base + 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_hs_count", hs_cnt - base, 4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("t4_idle", 200);
    for (int i = 0; i < 4; i++) begin
      g = (i < glog.size()) ? glog[i] : '0;
      check("t4_grant", g, (i % 2 == 1) ? 4'b0100 : 4'b0001);
    end
    check("t4_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
